noc_responder_q: RTL and testbench

//  Parametrised queued responder between requestor NoC and responder NoC. Accepts read

---
 rtl/noc_responder_q.sv | 136 +++++++++++++
 tb/tb_noc_responder_q.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_responder_q.sv
// Queued read responder: buffers read requests, reads the local register file
// and emits one response packet per request under responder-NoC back-pressure.
module noc_responder_q #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 6,
  parameter int DEST_W = 2,
  parameter int ID_W   = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ID_W-1:0]                       my_id,
  input  logic [REG_W+DEST_W:0]                 req_pkt,
  output logic                                  req_ready,
  output logic                                  rd_en,
  output logic [REG_W-1:0]                      rd_addr,
  input  logic [DATA_W-1:0]                     rd_data,
  input  logic                                  full,
  input  logic                                  almost_full,
  output logic [DATA_W+REG_W+ID_W+DEST_W:0]     dataOut,
  output logic                                  write,
  output logic                                  busy,
  output logic [CNT_W-1:0]                      drop_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int ENT_W  = REG_W + DEST_W;
  localparam int RESP_W = DATA_W + REG_W + ID_W + DEST_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t                 state_q, state_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]       mem_q [DEPTH];
  logic [ENT_W-1:0]       mem_d [DEPTH];
  logic [REG_W-1:0]       lat_reg_q, lat_reg_d;
  logic [DEST_W-1:0]      lat_dest_q, lat_dest_d;
  logic [RESP_W-1:0]      data_out_q, data_out_d;
  logic                   write_q, write_d;
  logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

  logic                   fifo_empty, fifo_full, push, pop, gate_open;
  logic [ENT_W-1:0]       head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign req_ready  = ~fifo_full;
  assign push       = req_pkt[0] & ~fifo_full;
  // Gate looks at the strobe currently on the wire: a live write consumes the last slot.
  assign gate_open  = ~((write_q & almost_full) | (~write_q & full));

  assign rd_addr  = head[ENT_W-1:DEST_W];
  assign dataOut  = data_out_q;
  assign write    = write_q;
  assign busy     = ~fifo_empty | (state_q != IDLE);
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = req_pkt[REG_W+DEST_W:1];
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (req_pkt[0] && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    rd_en      = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    lat_reg_d  = lat_reg_q;
    lat_dest_d = lat_dest_q;
    data_out_d = data_out_q;
    write_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en      = 1'b1;
          pop        = 1'b1;
          lat_reg_d  = head[ENT_W-1:DEST_W];
          lat_dest_d = head[DEST_W-1:0];
          state_d    = WAIT;
        end
      end
      WAIT: begin
        data_out_d = {rd_data, lat_reg_q, my_id, lat_dest_q, 1'b1};
        if (gate_open) begin
          write_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (gate_open) begin
          write_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      lat_reg_q  <= '0;
      lat_dest_q <= '0;
      data_out_q <= '0;
      write_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      lat_reg_q  <= lat_reg_d;
      lat_dest_q <= lat_dest_d;
      data_out_q <= data_out_d;
      write_q    <= write_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_noc_responder_q.sv
// Directed bench for noc_responder_q: latency, ordering, back-pressure,
// drop counting, FIFO wrap and asynchronous reset.
module tb_noc_responder_q;

  localparam logic [1:0] MY_ID = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  my_id;
  logic [8:0]  req_pkt;
  logic        req_ready, rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        full, almost_full;
  logic [26:0] dataOut;
  logic        write, busy;
  logic [7:0]  drop_cnt;

  noc_responder_q dut (
    .clk(clk), .reset(reset), .my_id(my_id), .req_pkt(req_pkt),
    .req_ready(req_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .full(full), .almost_full(almost_full), .dataOut(dataOut), .write(write),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [15:0] regs [64];
  logic [26:0] wq [$];
  int          wc [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en === 1'b1) rd_data <= regs[rd_addr];
  always @(negedge clk) if (write === 1'b1) begin
    wq.push_back(dataOut);
    wc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rq(input int r, input int d);
    logic [5:0] rr;
    logic [1:0] dd;
    rr = r[5:0];
    dd = d[1:0];
    return {rr, dd, 1'b1};
  endfunction

  function automatic logic [26:0] resp(input int r, input int d);
    logic [5:0] rr;
    logic [1:0] dd;
    rr = r[5:0];
    dd = d[1:0];
    return {regs[rr], rr, MY_ID, dd, 1'b1};
  endfunction

  task automatic wait_writes(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && wq.size() < n; k++) tick();
    chk(tag, wq.size(), n);
  endtask

  task automatic clear_log();
    wq.delete();
    wc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [26:0] snap;
    logic stable;

    for (int i = 0; i < 64; i++) regs[i] = 16'(32'hC000 + i * 17);
    regs[5] = 16'hBEEF;
    reset = 1'b1; my_id = MY_ID; req_pkt = '0; full = 1'b0; almost_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    chk("rst_dataOut", dataOut, 0);
    chk("rst_write", write, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_rd_en", rd_en, 0);

    // T1: single request, two-edge latency
    req_pkt = rq(5, 2);
    #1 chk("t1_ready", req_ready, 1);
    tick();
    req_pkt = '0;
    #1;
    chk("t1_rd_en", rd_en, 1);
    chk("t1_rd_addr", rd_addr, 5);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_write_wait", write, 0);
    tick();
    chk("t1_write", write, 1);
    chk("t1_data", dataOut, resp(5, 2));
    tick();
    chk("t1_write_one", write, 0);
    chk("t1_busy_done", busy, 0);
    clear_log();

    // T2: four back-to-back requests
    c0 = cyc;
    for (int i = 1; i <= 4; i++) begin
      req_pkt = rq(i, i);
      tick();
    end
    req_pkt = '0;
    wait_writes("t2_count", 4, 40);
    if (wq.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("t2_data%0d", k), wq[k], resp(k + 1, k + 1));
      for (int k = 1; k < 4; k++) chk($sformatf("t2_gap%0d", k), wc[k] - wc[k-1], 2);
      chk("t2_latency", wc[0], c0 + 3);
    end
    tick();
    chk("t2_busy_done", busy, 0);
    clear_log();

    // T3: full held, response parked in SEND
    full = 1'b1;
    req_pkt = rq(7, 1);
    tick();
    req_pkt = '0;
    repeat (3) tick();
    snap = dataOut;
    chk("t3_parked_data", snap, resp(7, 1));
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dataOut !== snap || write !== 1'b0) stable = 1'b0;
    end
    chk("t3_stable", stable, 1);
    chk("t3_busy", busy, 1);
    chk("t3_no_write", wq.size(), 0);
    full = 1'b0;
    c0 = cyc;
    wait_writes("t3_count", 1, 10);
    if (wq.size() >= 1) chk("t3_release_cycle", wc[0], c0 + 1);
    tick();
    chk("t3_write_one", write, 0);
    clear_log();

    // T4: almost_full alone does not stall a WAIT exit (write is 0 there)
    almost_full = 1'b1;
    req_pkt = rq(8, 0);
    tick();
    req_pkt = rq(9, 3);
    tick();
    req_pkt = '0;
    wait_writes("t4_count", 2, 20);
    if (wq.size() >= 2) begin
      chk("t4_data0", wq[0], resp(8, 0));
      chk("t4_data1", wq[1], resp(9, 3));
      chk("t4_gap", wc[1] - wc[0], 2);
    end
    almost_full = 1'b0;
    repeat (2) tick();
    clear_log();

    // T5: one response parked, then 6 requests into a 4-deep FIFO
    full = 1'b1;
    req_pkt = rq(10, 2);
    tick();
    req_pkt = '0;
    repeat (4) tick();
    for (int j = 0; j < 6; j++) begin
      req_pkt = rq(11 + j, j);
      #1 chk($sformatf("t5_ready%0d", j), req_ready, (j < 4) ? 1 : 0);
      tick();
    end
    req_pkt = '0;
    chk("t5_drop", drop_cnt, 2);
    chk("t5_no_write", wq.size(), 0);
    full = 1'b0;
    wait_writes("t5_count", 5, 40);
    if (wq.size() >= 5) begin
      chk("t5_data0", wq[0], resp(10, 2));
      for (int k = 1; k < 5; k++) chk($sformatf("t5_data%0d", k), wq[k], resp(10 + k, k - 1));
    end
    repeat (4) tick();
    chk("t5_extra", wq.size(), 5);
    chk("t5_busy_done", busy, 0);
    clear_log();

    // T6: asynchronous reset while parked with 3 queued
    full = 1'b1;
    req_pkt = rq(20, 1);
    tick();
    req_pkt = '0;
    repeat (4) tick();
    for (int j = 21; j <= 23; j++) begin
      req_pkt = rq(j, 0);
      tick();
    end
    req_pkt = '0;
    chk("t6_busy_before", busy, 1);
    chk("t6_drop_before", drop_cnt, 2);
    #2 reset = 1'b1;
    #1;
    chk("t6_write", write, 0);
    chk("t6_busy", busy, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_data", dataOut, 0);
    tick();
    reset = 1'b0;
    full = 1'b0;
    clear_log();
    repeat (12) tick();
    chk("t6_no_resp", wq.size(), 0);
    chk("t6_idle", busy, 0);

    // T7: drop counter saturates
    full = 1'b1;
    req_pkt = rq(30, 1);
    repeat (270) tick();
    req_pkt = '0;
    #1;
    chk("t7_drop_sat", drop_cnt, 8'hFF);
    chk("t7_ready", req_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
